result_display: RTL
===================

// Module: result_display
// PURPOSE
//  Downstream consumer of the 8-bit signed ALU result Y. Captures Y on a load strobe
//  (driven by the ALU enable). Converts |Y| to three BCD digits with an iterative
//  double-dabble engine. Time-multiplexes sign plus hundreds/tens/units onto a
//  4-digit active-low 7-segment display.
// PARAMETERS
//  SCAN_DIV  16'd50000  clk cycles per digit slot; legal range >= 2
// PORTS
//  clk    in   1  system clock, rising edge
//  reset  in   1  synchronous, active-high reset
//  Y      in   8  signed ALU result, sampled only on an accepted load
//  load   in   1  capture request; one or more cycles high
//  busy   out  1  conversion in progress; load ignored while high
//  done   out  1  one-cycle pulse when new digits are committed to display
//  seg    out  7  segments {g,f,e,d,c,b,a}, active-low
//  an     out  4  digit enables, active-low; an[0]=units, an[3]=sign
//  dp     out  1  decimal point, active-low; constant 1 (off)
// BEHAVIOUR
//  Reset values: busy=0, done=0, an=4'b1111, seg=7'h7F, dp=1.
//   Display registers = {sign=0, H=0, T=0, U=0}; scan counter=0; digit index=0.
//  FSM states: IDLE -> CONV -> COMMIT -> IDLE.
//  IDLE, load=1 at edge N:
//   - latch neg=Y[7] and mag=|Y| as 8-bit unsigned (-128 -> 8'd128, no overflow);
//   - clear BCD scratch; bit counter=0; state -> CONV; busy=1 after edge N.
//  CONV (edges N+1..N+8), each cycle:
//   - add 3 to each scratch BCD nibble >= 5;
//   - then shift {bcd[11:0],mag} left 1; bit counter += 1;
//   - after the 8th shift, state -> COMMIT.
//  COMMIT (edge N+9):
//   - copy scratch to display regs {neg,H,T,U};
//   - done=1 for exactly this cycle; busy=0 after edge N+9; state -> IDLE.
//  Latency: load accepted -> display regs updated 9 cycles later. A held load
//   re-triggers on the first IDLE cycle after COMMIT.
//  load while busy: ignored, not queued. Y may change freely while busy.
//  Display regs hold the previous value throughout CONV (no flicker/partial digits).
//  Scan: counter 0..SCAN_DIV-1. At terminal count, counter wraps to 0 and
//   digit index advances 0->1->2->3->0.
//   an = ~(4'b0001 << index); an is valid from the first cycle after reset exit.
//  seg per index:
//   - 0 -> U; 1 -> T; 2 -> H;
//   - 3 -> '-' (7'b0111111) if sign=1, else blank (7'h7F).
//  Digit codes 0-9 (active-low gfedcba):
//   40,79,24,30,19,12,02,78,00,10 (hex).
//  seg and an change on the same edge; both are registered.
//  reset mid-conversion: FSM -> IDLE, busy=0, display regs cleared, no done pulse.
//  Y=0 with sign: a 0 value is never negative, so the sign digit is blank.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined:
//   - H blanked when H=0;
//   - T blanked when H=0 and T=0;
//   - U always shown; sign digit unaffected (e.g. -5 shows "-  5").
//  Not defined: all three digits always shown (e.g. -5 shows "-005").
// TESTING
//  Run with SCAN_DIV=4.
//  T1 reset held 3 cycles then released:
//   - busy=0, an=1110 first; seg=7'h40 ("0"); index advances every 4 clk.
//  T2 Y=8'sd127, load 1 cycle:
//   - busy high exactly 9 cycles; done pulse on 9th;
//   - digits U=7,T=2,H=1; sign digit blank.
//  T3 Y=-8'sd128:
//   - H=1,T=2,U=8; an=0111 shows seg=7'b0111111.
//  T4 Y=-8'sd5:
//   - macro off: hundreds and tens show 7'h40;
//   - macro on: hundreds and tens show 7'h7F; units 7'h12.
//  T5 load Y=42, then load Y=99 at 3rd busy cycle:
//   - second load ignored; display shows 42;
//   - a fresh load after done shows 99.
//  T6 reset asserted at 4th CONV cycle after loading 100:
//   - busy=0, no done; display "000"/"0"; scan restarts at index 0.

Source files
------------

// File: rtl/result_display.sv
// result_display: latches signed Y, converts |Y| to BCD by double-dabble, scans sign/H/T/U on a 4-digit 7-seg.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens.
module result_display #(
    parameter logic [15:0] SCAN_DIV = 16'd50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] Y,
    input  logic       load,
    output logic       busy,
    output logic       done,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);
    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic LZB = 1'b1;
`else
    localparam logic LZB = 1'b0;
`endif
    state_t      r_state, w_next;
    logic [7:0]  r_mag;
    logic [11:0] r_bcd;
    logic [7:0]  w_adj;
    logic [2:0]  r_cnt;
    logic        r_neg, r_sign;
    logic [3:0]  r_h, r_t, r_u;
    logic [15:0] r_scan;
    logic [1:0]  r_idx;
    logic [6:0]  r_seg, w_seg;
    logic [3:0]  r_an;
    logic        w_tc, w_blank_h, w_blank_t;

    function automatic logic [6:0] f_dec(input logic [3:0] d);
        case (d)
            4'd0: f_dec = 7'h40;
            4'd1: f_dec = 7'h79;
            4'd2: f_dec = 7'h24;
            4'd3: f_dec = 7'h30;
            4'd4: f_dec = 7'h19;
            4'd5: f_dec = 7'h12;
            4'd6: f_dec = 7'h02;
            4'd7: f_dec = 7'h78;
            4'd8: f_dec = 7'h00;
            4'd9: f_dec = 7'h10;
            default: f_dec = 7'h7F;
        endcase
    endfunction

    // hundreds never exceeds 2 for an 8-bit magnitude, so only units and tens need the +3 step
    genvar g;
    for (g = 0; g < 2; g++) begin : g_adj
        assign w_adj[4*g+:4] = r_bcd[4*g+:4] >= 4'd5 ? r_bcd[4*g+:4] + 4'd3 : r_bcd[4*g+:4];
    end

    always_ff @(posedge clk)
        if (reset) r_state <= IDLE;
        else r_state <= w_next;

    always_comb begin
        w_next = r_state == IDLE ? (load ? CONV : IDLE)
               : r_state == CONV ? (r_cnt == 3'd7 ? COMMIT : CONV) : IDLE;
        busy   = r_state != IDLE;
        done   = r_state == COMMIT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mag  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_neg  <= 1'b0;
            r_sign <= 1'b0;
            r_h    <= '0;
            r_t    <= '0;
            r_u    <= '0;
        end else if (r_state == IDLE && load) begin
            r_neg <= Y[7];
            r_mag <= Y[7] ? ~Y + 8'd1 : Y;
            r_bcd <= '0;
            r_cnt <= '0;
        end else if (r_state == CONV) begin
            {r_bcd, r_mag} <= {r_bcd[10:8], w_adj, r_mag, 1'b0};
            r_cnt          <= r_cnt + 3'd1;
        end else if (r_state == COMMIT) begin
            r_sign <= r_neg;
            {r_h, r_t, r_u} <= r_bcd;
        end
    end

    always_comb begin
        w_tc      = r_scan == SCAN_DIV - 16'd1;
        w_blank_h = LZB && r_h == 4'd0;
        w_blank_t = w_blank_h && r_t == 4'd0;
        w_seg     = r_idx == 2'd0 ? f_dec(r_u)
                  : r_idx == 2'd1 ? (w_blank_t ? 7'h7F : f_dec(r_t))
                  : r_idx == 2'd2 ? (w_blank_h ? 7'h7F : f_dec(r_h))
                  : (r_sign ? 7'b0111111 : 7'h7F);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_scan <= '0;
            r_idx  <= '0;
            r_an   <= 4'b1111;
            r_seg  <= 7'h7F;
        end else begin
            r_scan <= w_tc ? 16'd0 : r_scan + 16'd1;
            r_idx  <= w_tc ? r_idx + 2'd1 : r_idx;
            r_an   <= ~(4'b0001 << r_idx);
            r_seg  <= w_seg;
        end
    end

    assign seg = r_seg;
    assign an  = r_an;
    assign dp  = 1'b1;
endmodule
